// File: rtl/of_pkg.sv
// Shared widths and the output-register record for the operand fetch stage.
package of_pkg;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] rd;
    logic              rd_we;
    logic [CTRL_W-1:0] ctrl;
  } of_out_t;

endpackage

// File: rtl/of_scoreboard.sv
// Pending-write bitmap: one bit per register, set on issue, cleared on writeback.
module of_scoreboard
  import of_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  output logic [NREGS-1:0]  pending,
  output logic              sb_busy
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // A new writer issued in the same cycle as the old one retires keeps the bit set.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
      always_comb begin
        pending_d[gi] = pending_q[gi];
        if (set_en && set_idx == ADDR_W'(gi)) begin
          pending_d[gi] = 1'b1;
        end else if (clr_en && clr_idx == ADDR_W'(gi)) begin
          pending_d[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign sb_busy = |pending_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: bank read addressing, writeback bypass, scoreboard hazard stall
// and a valid/ready output register toward execute.
module operand_fetch_stage #(
  parameter int DATA_W = of_pkg::DATA_W,
  parameter int ADDR_W = of_pkg::ADDR_W,
  parameter int CTRL_W = of_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_use1,
  input  logic              in_use2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [ADDR_W-1:0] sr1,
  output logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] regd1,
  input  logic [DATA_W-1:0] regd2,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              sb_busy
);

  import of_pkg::of_out_t;

  of_out_t                 out_q;
  of_out_t                 out_d;
  logic                    out_valid_q;
  logic                    out_valid_d;
  logic [(1<<ADDR_W)-1:0]  pending;
  logic                    byp1;
  logic                    byp2;
  logic                    byp_rd;
  logic                    hazard;
  logic                    accept;

  assign sr1 = in_rs1;
  assign sr2 = in_rs2;

  assign byp1   = wb_write && (wb_dr == in_rs1);
  assign byp2   = wb_write && (wb_dr == in_rs2);
  assign byp_rd = wb_write && (wb_dr == in_rd);

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  assign hazard = (in_use1  && pending[in_rs1] && !byp1)
               || (in_use2  && pending[in_rs2] && !byp2)
               || (in_rd_we && pending[in_rd]  && !byp_rd);

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d.op1   = byp1 ? wb_data : regd1;
      out_d.op2   = byp2 ? wb_data : regd2;
      out_d.rd    = in_rd;
      out_d.rd_we = in_rd_we;
      out_d.ctrl  = in_ctrl;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  of_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && in_rd_we),
    .set_idx (in_rd),
    .clr_en  (wb_write),
    .clr_idx (wb_dr),
    .pending (pending),
    .sb_busy (sb_busy)
  );

  assign out_valid = out_valid_q;
  assign out_op1   = out_q.op1;
  assign out_op2   = out_q.op2;
  assign out_rd    = out_q.rd;
  assign out_rd_we = out_q.rd_we;
  assign out_ctrl  = out_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed scenarios plus randomized traffic against a scoreboard/bank reference model.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_use1 = 1'b0, in_use2 = 1'b0, in_rd_we = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [4:0]  sr1, sr2;
  logic [31:0] regd1, regd2;
  logic        wb_write = 1'b0;
  logic [4:0]  wb_dr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [7:0]  out_ctrl;
  logic        sb_busy;

  int checks = 0;
  int errors = 0;

  // Environment register bank and reference model state
  logic [31:0] bank [32];
  bit          m_pend [32];
  bit          m_valid;
  logic [31:0] m_op1, m_op2;
  logic [4:0]  m_rd;
  logic        m_rd_we;
  logic [7:0]  m_ctrl;
  bit          last_acc;
  bit          last_rdy;

  always #5 clk = ~clk;

  assign regd1 = bank[sr1];
  assign regd2 = bank[sr2];

  operand_fetch_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use1(in_use1), .in_use2(in_use2),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_ctrl(in_ctrl),
    .sr1(sr1), .sr2(sr2), .regd1(regd1), .regd2(regd2),
    .wb_write(wb_write), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_ctrl(out_ctrl), .sb_busy(sb_busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rd_we = 1'b0; m_ctrl = '0;
  endfunction

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int i = 0; i < 32; i++) b |= m_pend[i];
    return b;
  endfunction

  task automatic check_outputs();
    check_val("out_valid", out_valid, m_valid);
    check_val("out_op1",   out_op1,   m_op1);
    check_val("out_op2",   out_op2,   m_op2);
    check_val("out_rd",    out_rd,    m_rd);
    check_val("out_rd_we", out_rd_we, m_rd_we);
    check_val("out_ctrl",  out_ctrl,  m_ctrl);
    check_val("sb_busy",   sb_busy,   model_busy());
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    bit haz, rdy, acc;
    bit n_valid;
    logic [31:0] b1, b2;
    #1;
    haz = (in_use1  && m_pend[in_rs1] && !(wb_write && wb_dr == in_rs1))
       || (in_use2  && m_pend[in_rs2] && !(wb_write && wb_dr == in_rs2))
       || (in_rd_we && m_pend[in_rd]  && !(wb_write && wb_dr == in_rd));
    rdy = (!m_valid || out_ready) && !haz;
    acc = in_valid && rdy;
    check_val("in_ready", in_ready, rdy);
    check_val("sr1", sr1, in_rs1);
    check_val("sr2", sr2, in_rs2);
    b1 = (wb_write && wb_dr == in_rs1) ? wb_data : bank[in_rs1];
    b2 = (wb_write && wb_dr == in_rs2) ? wb_data : bank[in_rs2];
    n_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    @(posedge clk);
    #1;
    if (acc) begin
      m_op1 = b1; m_op2 = b2; m_rd = in_rd; m_rd_we = in_rd_we; m_ctrl = in_ctrl;
      $display("issue rs1=%0d rs2=%0d rd=%0d we=%0b op1=%h op2=%h", in_rs1, in_rs2, in_rd, in_rd_we, b1, b2);
    end
    m_valid = n_valid;
    if (wb_write) m_pend[wb_dr] = 1'b0;
    if (acc && in_rd_we) m_pend[in_rd] = 1'b1;
    if (wb_write) bank[wb_dr] = wb_data;
    last_acc = acc;
    last_rdy = rdy;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd, input bit we);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_use1 = u1; in_use2 = u2;
    in_rd = rd; in_rd_we = we; in_ctrl = 8'($urandom);
  endtask

  task automatic wb(input bit w, input logic [4:0] dr, input logic [31:0] d);
    wb_write = w; wb_dr = dr; wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = $urandom;
    bank[3] = 32'h11;
    bank[4] = 32'h22;
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Plain read of preloaded registers
    drive(1, 3, 4, 1, 1, 0, 0);
    step();
    check_val("basic_op1", out_op1, 32'h11);
    check_val("basic_op2", out_op2, 32'h22);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    // RAW stall until writeback, then same-cycle bypass
    drive(1, 0, 0, 0, 0, 5, 1);
    step();
    drive(1, 5, 0, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("raw_stall", last_rdy, 1'b0);
    end
    wb(1, 5, 32'hABCD);
    step();
    check_val("raw_accept", last_acc, 1'b1);
    check_val("raw_bypass", out_op1, 32'hABCD);
    wb(0, 0, 0);

    // Unused source never hazards
    drive(1, 0, 0, 0, 0, 5, 1);
    step();
    drive(1, 5, 5, 0, 0, 2, 0);
    step();
    check_val("unused_src", last_acc, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0);
    wb(1, 5, 32'h5555);
    step();
    wb(0, 0, 0);

    // WAW: set wins over simultaneous clear
    drive(1, 0, 0, 0, 0, 7, 1);
    step();
    drive(1, 0, 0, 0, 0, 7, 1);
    step();
    check_val("waw_stall", last_acc, 1'b0);
    wb(1, 7, 32'h7777);
    step();
    check_val("waw_accept", last_acc, 1'b1);
    check_val("waw_busy", sb_busy, 1'b1);
    wb(0, 0, 0);
    drive(1, 7, 0, 1, 0, 0, 0);
    step();
    check_val("waw_still_pending", last_rdy, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    wb(1, 7, 32'h7778);
    step();
    wb(0, 0, 0);

    // Backpressure: outputs hold, stage stalls, then drains
    drive(1, 1, 2, 1, 1, 0, 0);
    out_ready = 1'b0;
    step();
    drive(1, 3, 4, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("bp_stall", last_rdy, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check_val("bp_drain_accept", last_acc, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] dr;
      int cnt;
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      dr = 5'($urandom_range(0, 31));
      cnt = 0;
      for (int i = 0; i < 8; i++) if (m_pend[i] && $urandom_range(0, 1) == 1 && cnt == 0) begin
        dr = 5'(i); cnt++;
      end
      wb($urandom_range(0, 1), dr, $urandom);
      step();
    end
    wb(0, 0, 0);
    out_ready = 1'b1;

    // Asynchronous reset with work in flight
    drive(1, 0, 0, 0, 0, 9, 1);
    out_ready = 1'b0;
    step();
    step();
    check_val("pre_reset_valid", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("async_valid", out_valid, 1'b0);
    check_val("async_busy", sb_busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    wb(1, 9, 32'h9999);
    step();
    wb(0, 0, 0);
    drive(1, 9, 0, 1, 0, 9, 1);
    step();
    check_val("post_reset_issue", last_acc, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
